t03_mem_responder: RTL and testbench
====================================

# t03_mem_responder

Memory-side responder for the CPU's request unit: accepts the single-word read/write requests the request unit issues (level-held `read`/`write`, `address`, write data) and answers each with a one-cycle `ack` after a programmable wait. It holds a word-addressed data/instruction memory and returns read data alongside `ack`. It sits between the request unit and the memory array, standing in for the external bus responder in simulation and in small builds.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two.
- `LATENCY`, 2: wait cycles inserted before `ack`; range 0–15.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `read` input 1: read request, held by the initiator until `ack`.
- `write` input 1: write request, held by the initiator until `ack`; wins over `read`.
- `address` input 32: byte address; word index `address[log2(DEPTH)+1:2]`.
- `wdata` input 32: write data, sampled with the request.
- `rdata` output 32: read data, valid only in the `ack` cycle.
- `ack` output 1: one-cycle completion pulse.
- `busy` output 1: high while a request is captured and not yet acked.
- `err` output 1: qualifies `ack`; request was misaligned or out of range.

## Operation
- States: IDLE, WAIT, ACK. Reset and idle state is IDLE.
- IDLE, `read|write` high: capture `address`, `wdata`, op (write if `write`, else read), and error = `address[1:0]!=0` or `address >= 4*DEPTH`.
  - If `LATENCY==0`, go to ACK.
  - Otherwise load the counter with `LATENCY-1` and go to WAIT.
- IDLE, no request: stay.
- WAIT: decrement the counter; at 0 go to ACK. Inputs are ignored; the captured values are used.
- Transition into ACK (the same edge):
  - Captured write without error: update the memory word.
  - Captured read without error: register the word into `rdata`.
  - Error, or write: `rdata` = 0.
- ACK: `ack`=1, `err`=captured error. Go to IDLE unconditionally. Any `read`/`write` still high in this cycle is the old request and is not resampled.
- Errored writes leave the memory unchanged.
- `busy` = state is WAIT or ACK.
- Memory contents are not reset.
- Reset values: `ack`=0, `err`=0, `busy`=0, `rdata`=0, counter=0, state IDLE.

## Timing
- A request first seen high in IDLE at cycle 0 produces `ack` high in cycle `LATENCY+1` only.
- The earliest next request is sampled in cycle `LATENCY+2`.
- Back-to-back throughput: one word per `LATENCY+2` cycles.
- Read-after-write to the same word in consecutive requests returns the new data.
- `read` and `write` both high: treated as a write, with no error.
- Request dropped before `ack`: ignored; the captured transaction still completes and acks.
- `rst` low mid-transaction: immediately IDLE and outputs at reset values. A pending write is not committed unless its commit edge has already occurred.
- Wrap: the counter never wraps, because it is loaded only from IDLE.
- Out-of-range upper address bits are never aliased; they set `err`.

## Structure
- Package `t03_mem_pkg` holds:
  - the state enum (IDLE=2'b00, WAIT=2'b01, ACK=2'b10);
  - `WORD_W=32`;
  - the latency counter width (4).
- Sub-module `t03_mem_array`: synchronous single-port word RAM, no reset.
  - Ports: `clk`, `we`, `idx`, `wd`, `rd`.
  - The read is registered on the same edge as the write enable is sampled.
- The top level holds the FSM, capture registers, counter and error logic.

## Test plan
- Reset: hold `rst`=0 with `read`=1 → `ack`,`busy`,`err`,`rdata` all 0. Release, `LATENCY`=2 → `ack` exactly in cycle 3 after the first sampled cycle.
- Write then read: write `0xDEADBEEF` to `0x10` (ack, `err`=0), then immediately read `0x10` → `rdata`=`0xDEADBEEF` in its ack cycle. The next request is accepted in cycle `LATENCY+2`.
- `LATENCY`=0 back-to-back reads of `0x0`,`0x4`,`0x8` with request held through `ack` → one ack per 2 cycles, no double-acks, data matches preload.
- Error cases, each giving `ack`=1, `err`=1, `rdata`=0:
  - read `0x2` (misaligned);
  - write `0x1000` with `DEPTH`=1024 (out of range); the memory is unchanged afterwards.
- Simultaneous `read`=`write`=1 to `0x20` with `wdata`=`0x1234` → treated as a write; a later read returns `0x1234`.
- `rst` asserted in WAIT of a write to `0x30` → no ack, outputs 0 asynchronously, and a later read of `0x30` returns the old value.

Source files
------------

// File: rtl/t03_mem_pkg.sv
// Shared types and constants for the memory responder:
// FSM state encoding, data word width and wait-counter width.
package t03_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ACK  = 2'b10
    } state_t;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

endpackage

// File: rtl/t03_mem_array.sv
// Synchronous single-port word RAM. The read is registered on the same edge
// that samples the write enable, so a same-edge write/read returns old data.
module t03_mem_array
    import t03_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [WORD_W-1:0]        wd,
    output logic [WORD_W-1:0]        rd
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset branch on purpose; a reset loop
    // over every word would stop it mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
        rd <= mem[idx];
    end

endmodule

// File: rtl/t03_mem_responder.sv
// Memory-side responder: captures one read/write request, waits LATENCY
// cycles, commits to the word RAM and acknowledges with a one-cycle pulse.
module t03_mem_responder
    import t03_mem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read,
    input  logic              write,
    input  logic [WORD_W-1:0] address,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              cap_write;
    logic              cap_err;
    logic [AW-1:0]     cap_idx;
    logic [WORD_W-1:0] cap_wdata;
    logic              rd_ok;

    logic              req;
    logic              req_err;
    logic              going_ack;
    logic              cur_write;
    logic              cur_err;
    logic [AW-1:0]     cur_idx;
    logic [WORD_W-1:0] cur_wdata;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rd;

    assign req     = read | write;
    assign req_err = (address[1:0] != 2'b00) || (|address[WORD_W-1:AW+2]);

    // NOTE: state and every other register use non-blocking assignments so all
    // flops update together from pre-edge values, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: each combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = (LATENCY == 0) ? ACK : WAIT;
            WAIT:    if (cnt == '0) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack  = 1'b0;
        busy = 1'b0;
        err  = 1'b0;
        if (state == ACK) begin
            ack = 1'b1;
            err = cap_err;
        end
        if (state != IDLE) begin
            busy = 1'b1;
        end
    end

    // With zero latency the commit edge is also the capture edge, so the live
    // inputs stand in for the not-yet-loaded capture registers.
    always_comb begin
        cur_write = cap_write;
        cur_err   = cap_err;
        cur_idx   = cap_idx;
        cur_wdata = cap_wdata;
        if (state == IDLE) begin
            cur_write = write;
            cur_err   = req_err;
            cur_idx   = address[AW+1:2];
            cur_wdata = wdata;
        end
    end

    assign going_ack = (state != ACK) && (state_next == ACK);
    assign mem_we    = rst && going_ack && cur_write && !cur_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            rd_ok     <= 1'b0;
        end else begin
            if (state == IDLE && req) begin
                cap_write <= write;
                cap_err   <= req_err;
                cap_idx   <= address[AW+1:2];
                cap_wdata <= wdata;
                cnt       <= LOAD_VAL;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            rd_ok <= going_ack && !cur_write && !cur_err;
        end
    end

    assign rdata = rd_ok ? mem_rd : '0;

    t03_mem_array #(
        .DEPTH(DEPTH)
    ) u_array (
        .clk (clk),
        .we  (mem_we),
        .idx (cur_idx),
        .wd  (cur_wdata),
        .rd  (mem_rd)
    );

endmodule

// File: tb/tb_t03_mem_responder.sv
// Scoreboard bench for t03_mem_responder: one instance with LATENCY=2 and
// one with LATENCY=0; expected responses are queued by the driver.
module tb_t03_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        rd2 = 1'b0, wr2 = 1'b0;
    logic [31:0] addr2 = '0, wd2 = '0;
    logic [31:0] rdata2;
    logic        ack2, busy2, err2;

    logic        rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr0 = '0, wd0 = '0;
    logic [31:0] rdata0;
    logic        ack0, busy0, err0;

    exp_t q2[$];
    exp_t q0[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    t03_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .read(rd2), .write(wr2), .address(addr2),
        .wdata(wd2), .rdata(rdata2), .ack(ack2), .busy(busy2), .err(err2)
    );

    t03_mem_responder #(.DEPTH(1024), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .read(rd0), .write(wr0), .address(addr0),
        .wdata(wd0), .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitors: every ack must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ack2) begin
            if (q2.size() == 0) begin
                check("unexpected_ack_lat2", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("rdata_lat2", rdata2, e.rdata);
                check("err_lat2", {31'b0, err2}, {31'b0, e.err});
                check("busy_in_ack_lat2", {31'b0, busy2}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (ack0) begin
            if (q0.size() == 0) begin
                check("unexpected_ack_lat0", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q0.pop_front();
                check("rdata_lat0", rdata0, e.rdata);
                check("err_lat0", {31'b0, err0}, {31'b0, e.err});
            end
        end
    end

    task automatic drive(input bit sel0, input bit w, input bit r,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel0) begin
            wr0 = w; rd0 = r; addr0 = a; wd0 = d;
        end else begin
            wr2 = w; rd2 = r; addr2 = a; wd2 = d;
        end
    endtask

    task automatic push(input bit sel0, input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (sel0) q0.push_back(e);
        else      q2.push_back(e);
    endtask

    // Counts negedges until ack; returns at the negedge of the ack cycle.
    task automatic wait_ack(input bit sel0, input int exp_cyc, input string name);
        int cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if ((sel0 ? ack0 : ack2) === 1'b1) break;
            if (cyc > 50) begin
                $display("FAIL %s: ack timeout after %0d cycles", name, cyc);
                break;
            end
        end
        check(name, cyc, exp_cyc);
    endtask

    // Called at a negedge; returns at the negedge of the ack cycle with the
    // request still held, so the next call chains back-to-back.
    task automatic req(input bit sel0, input bit w, input bit r,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input bit exp_err,
                       input int exp_cyc, input string name);
        push(sel0, exp_rd, exp_err);
        drive(sel0, w, r, a, d);
        wait_ack(sel0, exp_cyc, name);
    endtask

    task automatic idle(input bit sel0, input int n);
        drive(sel0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // Reset held with a misaligned read pending: everything stays zero.
        push(1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0002, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_ack", {31'b0, ack2}, 32'd0);
        check("rst_busy", {31'b0, busy2}, 32'd0);
        check("rst_err", {31'b0, err2}, 32'd0);
        check("rst_rdata", rdata2, 32'd0);
        rst = 1'b1;
        wait_ack(1'b0, 3, "first_ack_latency");
        idle(1'b0, 2);

        // Write then immediate read of the same word.
        req(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, "wr_0x10_latency");
        req(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, 4, "rd_0x10_b2b_latency");
        idle(1'b0, 2);

        // Misaligned read.
        req(1'b0, 1'b0, 1'b1, 32'h2, 32'h0, 32'h0, 1'b1, 3, "rd_misaligned_latency");
        idle(1'b0, 1);

        // Out-of-range write must not alias onto word 0.
        req(1'b0, 1'b1, 1'b0, 32'h0, 32'h1111_0000, 32'h0, 1'b0, 3, "wr_0x0_latency");
        req(1'b0, 1'b1, 1'b0, 32'h1000, 32'h5555_5555, 32'h0, 1'b1, 4, "wr_oob_latency");
        req(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h1111_0000, 1'b0, 4, "rd_0x0_after_oob");
        idle(1'b0, 1);

        // read and write both high act as a write.
        req(1'b0, 1'b1, 1'b1, 32'h20, 32'h1234, 32'h0, 1'b0, 3, "rdwr_0x20_latency");
        req(1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 32'h1234, 1'b0, 4, "rd_0x20_latency");
        idle(1'b0, 1);

        // Request dropped after one cycle still completes.
        push(1'b0, 32'hDEAD_BEEF, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_ack(1'b0, 2, "dropped_req_latency");
        idle(1'b0, 1);

        // Reset in the middle of a write to 0x30 discards it.
        req(1'b0, 1'b1, 1'b0, 32'h30, 32'hCAFE_0030, 32'h0, 1'b0, 3, "wr_0x30_latency");
        idle(1'b0, 1);
        drive(1'b0, 1'b1, 1'b0, 32'h30, 32'h0000_0BAD);
        @(negedge clk);
        check("busy_in_wait", {31'b0, busy2}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy2}, 32'd0);
        check("async_rst_ack", {31'b0, ack2}, 32'd0);
        check("async_rst_rdata", rdata2, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        req(1'b0, 1'b0, 1'b1, 32'h30, 32'h0, 32'hCAFE_0030, 1'b0, 3, "rd_0x30_after_rst");
        idle(1'b0, 2);

        // Zero latency: preload then back-to-back reads held through ack.
        req(1'b1, 1'b1, 1'b0, 32'h0, 32'hA0A0_0000, 32'h0, 1'b0, 1, "l0_wr_0x0_latency");
        req(1'b1, 1'b1, 1'b0, 32'h4, 32'hA4A4_0004, 32'h0, 1'b0, 2, "l0_wr_0x4_latency");
        req(1'b1, 1'b1, 1'b0, 32'h8, 32'hA8A8_0008, 32'h0, 1'b0, 2, "l0_wr_0x8_latency");
        req(1'b1, 1'b0, 1'b1, 32'h0, 32'h0, 32'hA0A0_0000, 1'b0, 2, "l0_rd_0x0_latency");
        req(1'b1, 1'b0, 1'b1, 32'h4, 32'h0, 32'hA4A4_0004, 1'b0, 2, "l0_rd_0x4_latency");
        req(1'b1, 1'b0, 1'b1, 32'h8, 32'h0, 32'hA8A8_0008, 1'b0, 2, "l0_rd_0x8_latency");
        idle(1'b1, 4);

        check("q_lat2_drained", q2.size(), 32'd0);
        check("q_lat0_drained", q0.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
